// File: rtl/ll_stream_stage.sv
// ll_stream_stage: FIFO-buffered stream stage with a per-token transform and frame tracking.
// The send/ack handshake is combinational; occupancy is counted separately from the pointers.
`default_nettype none

module ll_stream_stage #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int MODE      = 0,
  parameter int SHIFT     = 1,
  parameter int FRAME_LEN = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic              In1_SEND,
  input  logic [15:0]       In1_COUNT,
  output logic              In1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic              Out1_SEND,
  output logic [15:0]       Out1_COUNT,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK,
  output logic [6:0]        LEVEL,
  output logic              FRAME_DONE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]        level_q, level_d;
  logic [15:0]       frame_q, frame_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] xform;
  logic              do_wr, do_rd, last_tok;
  logic              unused_inputs;

  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

  // Reset gates the strobes so they drop immediately, not at the next edge.
  assign do_wr    = RESET && In1_SEND && (level_q < 7'(DEPTH));
  assign do_rd    = RESET && Out1_RDY && (level_q != 7'd0);
  assign last_tok = (frame_q == 16'(FRAME_LEN - 1));

  assign In1_ACK    = do_wr;
  assign Out1_SEND  = do_rd;
  assign FRAME_DONE = do_rd && last_tok;
  assign Out1_COUNT = 16'h1;
  assign LEVEL      = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    frame_d  = frame_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      frame_d  = last_tok ? 16'd0 : frame_q + 16'd1;
    end
    if (do_wr && !do_rd)      level_d = level_q + 7'd1;
    else if (!do_wr && do_rd) level_d = level_q - 7'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frame_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frame_q  <= frame_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q] <= In1_DATA;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    xform = head;
    if (MODE == 1) begin
      xform = DATA_W'($signed(head) >>> SHIFT);
    end else if (MODE == 2) begin
      if (head == MOST_NEG)     xform = ~MOST_NEG;
      else if (head[DATA_W-1])  xform = -head;
    end
  end

  assign Out1_DATA = (level_q != 7'd0) ? xform : '0;

endmodule

`default_nettype wire

// File: tb/tb_ll_stream_stage.sv
// Directed self-checking bench for ll_stream_stage: three instances cover MODE 0, 1 and 2.
`default_nettype none

module tb_ll_stream_stage;

  logic        CLK;
  logic        RESET;

  logic [15:0] a_in;   logic a_send, a_rdy;
  logic        a_ack, a_osend, a_fd;
  logic [15:0] a_out, a_ocnt;
  logic [6:0]  a_lvl;

  logic [15:0] b_in;   logic b_send, b_rdy;
  logic        b_ack, b_osend, b_fd;
  logic [15:0] b_out, b_ocnt;
  logic [6:0]  b_lvl;

  logic [15:0] c_in;   logic c_send, c_rdy;
  logic        c_ack, c_osend, c_fd;
  logic [15:0] c_out, c_ocnt;
  logic [6:0]  c_lvl;

  int errors = 0;
  int checks = 0;

  ll_stream_stage #(.DATA_W(16), .DEPTH(4), .MODE(0), .SHIFT(1), .FRAME_LEN(3)) dut0 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(a_in), .In1_SEND(a_send), .In1_COUNT(16'd0),
    .In1_ACK(a_ack), .Out1_DATA(a_out), .Out1_SEND(a_osend), .Out1_COUNT(a_ocnt),
    .Out1_RDY(a_rdy), .Out1_ACK(1'b0), .LEVEL(a_lvl), .FRAME_DONE(a_fd));

  ll_stream_stage #(.DATA_W(16), .DEPTH(4), .MODE(1), .SHIFT(2), .FRAME_LEN(16)) dut1 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(b_in), .In1_SEND(b_send), .In1_COUNT(16'd0),
    .In1_ACK(b_ack), .Out1_DATA(b_out), .Out1_SEND(b_osend), .Out1_COUNT(b_ocnt),
    .Out1_RDY(b_rdy), .Out1_ACK(1'b0), .LEVEL(b_lvl), .FRAME_DONE(b_fd));

  ll_stream_stage #(.DATA_W(16), .DEPTH(4), .MODE(2), .SHIFT(1), .FRAME_LEN(16)) dut2 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(c_in), .In1_SEND(c_send), .In1_COUNT(16'd0),
    .In1_ACK(c_ack), .Out1_DATA(c_out), .Out1_SEND(c_osend), .Out1_COUNT(c_ocnt),
    .Out1_RDY(c_rdy), .Out1_ACK(1'b0), .LEVEL(c_lvl), .FRAME_DONE(c_fd));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b0; a_send = 1'b1; a_rdy = 1'b1; a_in = 16'h1234;
    #2;
    checks++; if (a_lvl !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", a_lvl); end
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack got=%b exp=0", a_ack); end
    checks++; if (a_osend !== 1'b0) begin errors++; $display("FAIL reset_out_send got=%b exp=0", a_osend); end
    checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", a_out); end
    checks++; if ({a_fd, b_fd, c_fd} !== 3'b000) begin errors++; $display("FAIL reset_frame_done got=%b exp=000", {a_fd, b_fd, c_fd}); end
    checks++; if ({a_ocnt, b_ocnt, c_ocnt} !== {16'h1, 16'h1, 16'h1}) begin errors++; $display("FAIL out_count got=%h/%h/%h exp=1", a_ocnt, b_ocnt, c_ocnt); end
    checks++; if ({b_lvl, c_lvl} !== 14'd0) begin errors++; $display("FAIL reset_level_bc got=%0d/%0d exp=0", b_lvl, c_lvl); end
    a_send = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [15:0] vin [3];
    vin[0] = 16'd5; vin[1] = 16'hFFFD; vin[2] = 16'd7;
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      a_send = (i < 3);
      if (i < 3) a_in = vin[i];
      #2;
      if (i < 3) begin
        checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL pass_ack[%0d] got=%b exp=1", i, a_ack); end
      end
      if (i == 0) begin
        checks++; if (a_osend !== 1'b0) begin errors++; $display("FAIL pass_no_bypass got=%b exp=0", a_osend); end
      end else begin
        checks++; if (a_osend !== 1'b1 || a_out !== vin[i-1])
          begin errors++; $display("FAIL pass_out[%0d] got=%b/%h exp=1/%h", i - 1, a_osend, a_out, vin[i-1]); end
      end
    end
    @(negedge CLK);
    a_send = 1'b0;
    #2;
    checks++; if (a_lvl !== 7'd0 || a_osend !== 1'b0) begin errors++; $display("FAIL pass_drain got=%0d/%b exp=0/0", a_lvl, a_osend); end
  endtask

  task automatic test_full();
    a_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      a_send = 1'b1; a_in = 16'(10 + i);
      #2;
      checks++; if (a_ack !== (i < 4)) begin errors++; $display("FAIL full_ack[%0d] got=%b exp=%b", i, a_ack, (i < 4)); end
    end
    checks++; if (a_lvl !== 7'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", a_lvl); end
    @(negedge CLK);
    a_rdy = 1'b1; a_in = 16'd14;
    #2;
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL full_ack_on_read got=%b exp=0", a_ack); end
    checks++; if (a_osend !== 1'b1 || a_out !== 16'd10) begin errors++; $display("FAIL full_emit got=%b/%0d exp=1/10", a_osend, a_out); end
    @(negedge CLK);
    a_rdy = 1'b0;
    #2;
    checks++; if (a_ack !== 1'b1 || a_lvl !== 7'd3) begin errors++; $display("FAIL full_ack_next got=%b/%0d exp=1/3", a_ack, a_lvl); end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      a_send = 1'b0; a_rdy = 1'b1;
      #2;
      checks++; if (a_osend !== 1'b1 || a_out !== 16'(11 + i))
        begin errors++; $display("FAIL full_drain[%0d] got=%b/%0d exp=1/%0d", i, a_osend, a_out, 11 + i); end
    end
    @(negedge CLK);
    a_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] q [$];
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge CLK);
      a_send = (sent < 10); a_in = 16'(100 + sent); a_rdy = cyc[0];
      #2;
      checks++; if (a_lvl > 7'd4) begin errors++; $display("FAIL wrap_level got=%0d exp<=4", a_lvl); end
      if (a_osend) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL wrap_spurious got=%0d exp=none", a_out); end
        else begin
          if (a_out !== q[0]) begin errors++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", got, a_out, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (a_ack) begin q.push_back(a_in); sent++; end
    end
    checks++; if (got != 10 || sent != 10) begin errors++; $display("FAIL wrap_count got=%0d/%0d exp=10/10", sent, got); end
    @(negedge CLK);
    a_send = 1'b0; a_rdy = 1'b0;
  endtask

  task automatic test_transform();
    logic [15:0] bi [2], be [2], ci [3], ce [3];
    bi[0] = 16'hFFF9; be[0] = 16'hFFFE;
    bi[1] = 16'd20;   be[1] = 16'd5;
    ci[0] = 16'h8000; ce[0] = 16'h7FFF;
    ci[1] = 16'hFFFB; ce[1] = 16'd5;
    ci[2] = 16'd9;    ce[2] = 16'd9;
    b_rdy = 1'b1; c_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      b_send = (i < 2); if (i < 2) b_in = bi[i];
      c_send = (i < 3); if (i < 3) c_in = ci[i];
      #2;
      if (i >= 1 && i <= 2) begin
        checks++; if (b_osend !== 1'b1 || b_out !== be[i-1])
          begin errors++; $display("FAIL shift[%0d] got=%b/%h exp=1/%h", i - 1, b_osend, b_out, be[i-1]); end
      end
      if (i >= 1) begin
        checks++; if (c_osend !== 1'b1 || c_out !== ce[i-1])
          begin errors++; $display("FAIL abs[%0d] got=%b/%h exp=1/%h", i - 1, c_osend, c_out, ce[i-1]); end
      end
    end
    @(negedge CLK);
    b_send = 1'b0; c_send = 1'b0;
    #2;
    checks++; if (c_out !== 16'h0 || b_out !== 16'h0) begin errors++; $display("FAIL empty_out got=%h/%h exp=0/0", b_out, c_out); end
  endtask

  task automatic test_frames();
    int sent;
    int emits;
    @(negedge CLK);
    RESET = 1'b0; a_send = 1'b0; a_rdy = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    sent = 0; emits = 0; a_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 && emits < 7; cyc++) begin
      @(negedge CLK);
      a_send = (sent < 7); a_in = 16'(200 + sent);
      #2;
      if (a_osend) begin
        emits++;
        checks++; if (a_fd !== (emits == 3 || emits == 6))
          begin errors++; $display("FAIL frame_done[emit %0d] got=%b exp=%b", emits, a_fd, (emits == 3 || emits == 6)); end
      end
      if (a_ack) sent++;
    end
    checks++; if (emits != 7) begin errors++; $display("FAIL frame_emits got=%0d exp=7", emits); end
    @(negedge CLK);
    a_rdy = 1'b0; a_send = 1'b1; a_in = 16'd300;
    @(negedge CLK);
    a_in = 16'd301;
    @(negedge CLK);
    a_send = 1'b0;
    #2;
    checks++; if (a_lvl !== 7'd2) begin errors++; $display("FAIL frame_prefill got=%0d exp=2", a_lvl); end
    RESET = 1'b0;
    #1;
    checks++; if (a_lvl !== 7'd0 || a_out !== 16'h0) begin errors++; $display("FAIL midreset got=%0d/%h exp=0/0", a_lvl, a_out); end
    @(negedge CLK);
    RESET = 1'b1;
    sent = 0; emits = 0; a_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 && emits < 3; cyc++) begin
      @(negedge CLK);
      a_send = (sent < 3); a_in = 16'(400 + sent);
      #2;
      if (a_osend) begin
        emits++;
        checks++; if (a_fd !== (emits == 3))
          begin errors++; $display("FAIL frame_after_reset[emit %0d] got=%b exp=%b", emits, a_fd, (emits == 3)); end
        if (emits == 1) begin
          checks++; if (a_out !== 16'd400) begin errors++; $display("FAIL after_reset_data got=%0d exp=400", a_out); end
        end
      end
      if (a_ack) sent++;
    end
    checks++; if (emits != 3) begin errors++; $display("FAIL frame_after_reset_emits got=%0d exp=3", emits); end
    @(negedge CLK);
    a_send = 1'b0; a_rdy = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    a_in = '0; a_send = 1'b0; a_rdy = 1'b0;
    b_in = '0; b_send = 1'b0; b_rdy = 1'b0;
    c_in = '0; c_send = 1'b0; c_rdy = 1'b0;
    test_reset();
    test_passthrough();
    test_full();
    test_wrap();
    test_transform();
    test_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
